// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory (port 0 = core LSU, port 1 = debug/DMA loader).
// Latency: grant is combinational in the request cycle; read data returns one cycle after the grant.
// Backpressure: a denied request simply gets no grant and must be held. Port 1 is starved at most MAX_WAIT cycles.
//
// Ports:
//   clk, rst                     - sole clock; asynchronous active-high reset
//   pN_req/we/byte_en/addr/wdata - per-port request (N = 0, 1)
//   pN_gnt                       - request accepted this cycle (combinational)
//   pN_rvalid/pN_rdata           - registered read response; rdata is zero unless this port owns the response
//   mem_*                        - memory command for the granted port; mem_read_data returns one cycle later
module data_mem_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int MAX_WAIT = 4    // legal range 1..15
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [3:0]        p0_byte_en,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [3:0]        p1_byte_en,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,

  output logic              mem_write,
  output logic [3:0]        mem_byte_en,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // Starvation counter for port 1 and the single outstanding-read record.
  logic [3:0] wait_q, wait_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_own_q, rd_own_d;   // 0 = port 0 owns the response, 1 = port 1

  logic force1;
  logic p1_win;

  // Once port 1 has been denied MAX_WAIT cycles in a row it takes priority
  // until it is served; the counter stops incrementing at the threshold so
  // force1 stays asserted for as long as port 1 keeps waiting.
  assign force1 = (wait_q == MAX_WAIT_C);

  // Port 1 wins if it is alone, or if it has been starved long enough.
  assign p1_win = p1_req && (!p0_req || force1);

  // Reset gates the grants combinationally so nothing reaches memory while
  // rst is high, even in the cycle it first asserts.
  assign p1_gnt = !rst && p1_win;
  assign p0_gnt = !rst && p0_req && !p1_win;

  // Memory command mux. Idle cycles drive an all-zero command so the memory
  // never sees stale addresses or byte enables.
  always_comb begin
    mem_write      = 1'b0;
    mem_byte_en    = 4'b0000;
    mem_write_addr = '0;
    mem_read_addr  = '0;
    mem_write_data = 32'h0;
    if (p0_gnt) begin
      mem_write      = p0_we;
      mem_byte_en    = p0_byte_en;
      mem_write_addr = p0_addr;
      mem_read_addr  = p0_addr;
      mem_write_data = p0_wdata;
    end else if (p1_gnt) begin
      mem_write      = p1_we;
      mem_byte_en    = p1_byte_en;
      mem_write_addr = p1_addr;
      mem_read_addr  = p1_addr;
      mem_write_data = p1_wdata;
    end
  end

  // Wait counter: counts consecutive denied cycles of port 1, cleared when
  // port 1 is served or drops its request.
  always_comb begin
    wait_d = wait_q;
    if (!p1_req || p1_gnt) begin
      wait_d = 4'd0;
    end else if (!force1) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // A granted read produces exactly one response next cycle; writes
  // (including byte_en == 0 writes) never produce a response.
  always_comb begin
    rd_pend_d = (p0_gnt || p1_gnt) && !mem_write;
    rd_own_d  = p1_gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q    <= 4'd0;
      rd_pend_q <= 1'b0;
      rd_own_q  <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      rd_pend_q <= rd_pend_d;
      rd_own_q  <= rd_own_d;
    end
  end

  // Responses come straight from the memory's registered read port; the
  // pending flag is cleared asynchronously so a read in flight when reset
  // hits is dropped rather than delivered later.
  assign p0_rvalid = rd_pend_q && !rd_own_q;
  assign p1_rvalid = rd_pend_q &&  rd_own_q;
  assign p0_rdata  = p0_rvalid ? mem_read_data : 32'h0;
  assign p1_rdata  = p1_rvalid ? mem_read_data : 32'h0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vectors with literal expectations plus
// a per-cycle comparison against a behavioural model of arbitration and memory.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_data_mem_arbiter;
  localparam int ADDR_W   = 18;
  localparam int MAX_WAIT = 4;
  localparam int WORDS    = 1 << (ADDR_W - 2);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              p0_req, p0_we, p1_req, p1_we;
  logic [3:0]        p0_byte_en, p1_byte_en;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [31:0]       p0_wdata, p1_wdata;
  logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0]       p0_rdata, p1_rdata;
  logic              mem_write;
  logic [3:0]        mem_byte_en;
  logic [ADDR_W-1:0] mem_write_addr, mem_read_addr;
  logic [31:0]       mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_byte_en(p0_byte_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_byte_en(p1_byte_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_write(mem_write), .mem_byte_en(mem_byte_en), .mem_write_addr(mem_write_addr),
    .mem_read_addr(mem_read_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  // Preload contents shared by the attached memory and the model memory.
  function automatic logic [31:0] preload(input int idx);
    case (idx)
      0:       return 32'hCAFE0000;
      1:       return 32'hCAFE0004;
      2:       return 32'hCAFE0008;
      3:       return 32'hCAFE000C;
      64:      return 32'h11223344;   // byte address 0x100
      default: return 32'h0;
    endcase
  endfunction

  // Memory attached to the DUT: byte-lane writes, one-cycle registered read.
  logic [31:0] env_mem [WORDS];
  initial begin
    for (int i = 0; i < WORDS; i++) env_mem[i] = preload(i);
    mem_read_data = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byte_en[b]) env_mem[mem_write_addr[ADDR_W-1:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
      mem_read_data <= env_mem[mem_read_addr[ADDR_W-1:2]];
    end
  end

  // Behavioural model: port 1 is served when alone or once it has been
  // refused MAX_WAIT cycles in a row; each granted read is answered on the
  // following cycle with the model memory's contents at grant time.
  logic [31:0] ref_mem [WORDS];
  int          deny_run;
  bit          resp_vld, resp_p1;
  logic [31:0] resp_dat;

  initial begin
    bit                e0, e1, ewe;
    logic [3:0]        ebe;
    logic [ADDR_W-1:0] ea;
    logic [31:0]       ed;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = preload(i);
    deny_run = 0;
    resp_vld = 0;
    resp_p1  = 0;
    resp_dat = 0;
    forever begin
      @(negedge clk);
      e0 = 0; e1 = 0; ewe = 0; ebe = 0; ea = 0; ed = 0;
      if (rst) begin
        deny_run = 0;
        resp_vld = 0;
      end else begin
        e1 = p1_req && (!p0_req || deny_run >= MAX_WAIT);
        e0 = p0_req && !e1;
        if (e0) begin ewe = p0_we; ebe = p0_byte_en; ea = p0_addr; ed = p0_wdata; end
        if (e1) begin ewe = p1_we; ebe = p1_byte_en; ea = p1_addr; ed = p1_wdata; end
      end
      check("m_p0_gnt", p0_gnt, e0);
      check("m_p1_gnt", p1_gnt, e1);
      check("m_mem_write", mem_write, ewe);
      check("m_mem_byte_en", mem_byte_en, ebe);
      check("m_mem_write_addr", mem_write_addr, ea);
      check("m_mem_read_addr", mem_read_addr, ea);
      check("m_mem_write_data", mem_write_data, ed);
      check("m_p0_rvalid", p0_rvalid, resp_vld && !resp_p1);
      check("m_p1_rvalid", p1_rvalid, resp_vld && resp_p1);
      check("m_p0_rdata", p0_rdata, (resp_vld && !resp_p1) ? resp_dat : 32'h0);
      check("m_p1_rdata", p1_rdata, (resp_vld && resp_p1) ? resp_dat : 32'h0);
      if (!rst) begin
        deny_run = (p1_req && !e1) ? ((deny_run < MAX_WAIT) ? deny_run + 1 : MAX_WAIT) : 0;
        resp_vld = 0;
        if (e0 || e1) begin
          if (ewe) begin
            for (int b = 0; b < 4; b++)
              if (ebe[b]) ref_mem[ea[ADDR_W-1:2]][8*b +: 8] = ed[8*b +: 8];
          end else begin
            resp_vld = 1;
            resp_p1  = e1;
            resp_dat = ref_mem[ea[ADDR_W-1:2]];
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic r, input logic we, input logic [3:0] be,
                        input logic [ADDR_W-1:0] a, input logic [31:0] d);
    p0_req = r; p0_we = we; p0_byte_en = be; p0_addr = a; p0_wdata = d;
  endtask

  task automatic set_p1(input logic r, input logic we, input logic [3:0] be,
                        input logic [ADDR_W-1:0] a, input logic [31:0] d);
    p1_req = r; p1_we = we; p1_byte_en = be; p1_addr = a; p1_wdata = d;
  endtask

  task automatic idle();
    set_p0(0, 0, 4'h0, '0, 32'h0);
    set_p1(0, 0, 4'h0, '0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    // Requests during reset are refused; write is accepted on first edge after release.
    set_p0(1, 1, 4'hF, 18'h00010, 32'hDEADBEEF);
    @(negedge clk);
    check("rst_p0_gnt", p0_gnt, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_byte_en", mem_byte_en, 0);
    check("rst_p0_rvalid", p0_rvalid, 0);
    tick();
    rst = 0;
    @(negedge clk);
    check("a_wr_gnt", p0_gnt, 1);
    check("a_wr_data", mem_write_data, 32'hDEADBEEF);
    check("a_wr_addr", mem_write_addr, 32'h10);
    tick(); set_p0(1, 0, 4'h0, 18'h00010, 32'h0);
    @(negedge clk);
    check("a_rd_gnt", p0_gnt, 1);
    check("a_rd_rvalid_early", p0_rvalid, 0);
    tick(); idle();
    @(negedge clk);
    check("a_rvalid", p0_rvalid, 1);
    check("a_rdata", p0_rdata, 32'hDEADBEEF);
    check("a_p1_rvalid", p1_rvalid, 0);

    // Simultaneous request with no starvation history: port 0 wins.
    tick(); set_p0(1, 0, 4'h0, 18'h0, 32'h0); set_p1(1, 0, 4'h0, 18'h4, 32'h0);
    @(negedge clk);
    check("b_p0_gnt", p0_gnt, 1);
    check("b_p1_gnt", p1_gnt, 0);
    tick(); idle();

    // Both held high: p0 x4, p1, p0 x4, p1.
    tick(); set_p0(1, 0, 4'h0, 18'h8, 32'h0); set_p1(1, 0, 4'h0, 18'hC, 32'h0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("c_p1_gnt_cyc%0d", c), p1_gnt, (c % 5 == 0) ? 1 : 0);
      check($sformatf("c_p0_gnt_cyc%0d", c), p0_gnt, (c % 5 == 0) ? 0 : 1);
    end
    tick(); idle();

    // Partial write by p1, read back; then a zero-byte-enable write changes nothing.
    tick(); set_p1(1, 1, 4'b0010, 18'h00100, 32'h0000AB00);
    @(negedge clk);
    check("d_wr_gnt", p1_gnt, 1);
    check("d_wr_be", mem_byte_en, 4'b0010);
    tick(); set_p1(1, 0, 4'h0, 18'h00100, 32'h0);
    @(negedge clk);
    check("d_rd_gnt", p1_gnt, 1);
    tick(); set_p1(0, 0, 4'h0, '0, 32'h0); set_p0(1, 1, 4'h0, 18'h00100, 32'hFFFFFFFF);
    @(negedge clk);
    check("d_p1_rvalid", p1_rvalid, 1);
    check("d_p1_rdata", p1_rdata, 32'h1122AB44);
    check("d_p0_rdata_zero", p0_rdata, 0);
    check("d_be0_wr_gnt", p0_gnt, 1);
    tick(); set_p0(1, 0, 4'h0, 18'h00100, 32'h0);
    @(negedge clk);
    check("d_no_rvalid_for_write", p0_rvalid, 0);
    tick(); idle();
    @(negedge clk);
    check("d_be0_unchanged", p0_rdata, 32'h1122AB44);

    // Reset pulsed between a read grant and its response.
    tick(); set_p0(1, 0, 4'h0, 18'h4, 32'h0);
    @(negedge clk);
    check("e_rd_gnt", p0_gnt, 1);
    tick(); rst = 1; set_p0(1, 0, 4'h0, 18'h8, 32'h0);
    @(negedge clk);
    check("e_rst_rvalid", p0_rvalid, 0);
    check("e_rst_gnt", p0_gnt, 0);
    check("e_rst_mem_read_addr", mem_read_addr, 0);
    check("e_rst_p0_rdata", p0_rdata, 0);
    tick(); rst = 0; idle();
    @(negedge clk);
    check("e_post_rvalid", p0_rvalid, 0);
    tick();
    @(negedge clk);
    check("e_post_rvalid2", p0_rvalid, 0);

    // Four back-to-back reads: responses on four consecutive cycles, in order.
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k < 4) set_p0(1, 0, 4'h0, ADDR_W'(4 * k), 32'h0);
      else idle();
      @(negedge clk);
      if (k > 0) begin
        check($sformatf("f_rvalid_%0d", k), p0_rvalid, 1);
        check($sformatf("f_rdata_%0d", k), p0_rdata, 32'hCAFE0000 + 32'(4 * (k - 1)));
      end
    end

    // Write then read of the same word on consecutive cycles.
    tick(); set_p0(1, 1, 4'hF, 18'h00200, 32'h12345678);
    tick(); set_p0(1, 0, 4'h0, 18'h00202, 32'h0);   // low address bits ignored
    tick(); idle();
    @(negedge clk);
    check("g_wr_rd_fwd", p0_rdata, 32'h12345678);

    // Mixed traffic against the model; low address bits deliberately varied.
    for (int n = 0; n < 300; n++) begin
      tick();
      set_p0(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
             ADDR_W'($urandom_range(0, 63)), $urandom);
      set_p1(1'($urandom_range(0, 2) != 0), 1'($urandom), 4'($urandom),
             ADDR_W'($urandom_range(0, 63)), $urandom);
    end
    tick(); idle();
    tick();
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 18, byte address width toward data memory.
REQ-002 SHALL have parameter MAX_WAIT, default 4, range 1..15; cycles port 1 may be denied before it is forced to win.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have ports p0_req/p1_req, input, 1 each, access request; port 0 = core LSU, port 1 = debug/DMA loader.
REQ-006 SHALL have ports p0_we/p1_we, input, 1 each; 1 = write, 0 = read.
REQ-007 SHALL have ports p0_byte_en/p1_byte_en, input, 4 each, write byte lanes.
REQ-008 SHALL have ports p0_addr/p1_addr, input, ADDR_W each, byte address.
REQ-009 SHALL have ports p0_wdata/p1_wdata, input, 32 each, write data.
REQ-010 SHALL have ports p0_gnt/p1_gnt, output, 1 each, request accepted this cycle (combinational).
REQ-011 SHALL have ports p0_rvalid/p1_rvalid, output, 1 each, registered, read data valid.
REQ-012 SHALL have ports p0_rdata/p1_rdata, output, 32 each, read data, meaningful only while matching rvalid=1.
REQ-013 SHALL have ports mem_write (1), mem_byte_en (4), mem_write_addr (ADDR_W), mem_read_addr (ADDR_W), mem_write_data (32), all outputs; and mem_read_data, input, 32, memory read word with one-cycle synchronous latency.

Function
REQ-014 SHALL grant at most one port per cycle; a port is granted only while its req=1 and rst=0.
REQ-015 SHALL use fixed priority to port 0 unless force1=1, in which case port 1 wins over a simultaneous port 0 request.
REQ-016 SHALL keep a wait counter: +1 each cycle p1_req=1 and p1_gnt=0; cleared to 0 on p1_gnt=1 or when p1_req=0; saturates at MAX_WAIT.
REQ-017 SHALL derive force1 = (wait counter == MAX_WAIT); force1 remains until port 1 is granted.
REQ-018 SHALL, in a granted cycle, drive mem_write_addr and mem_read_addr = granted addr, mem_write_data = granted wdata, mem_byte_en = granted byte_en, mem_write = granted we.
REQ-019 SHALL, with no grant, drive mem_write=0, mem_byte_en=0, addresses and data = 0.
REQ-020 SHALL record owner and read flag of a granted read; in the next cycle assert that port's rvalid for exactly one cycle with rdata = mem_read_data.
REQ-021 SHALL never assert rvalid for writes; a write with byte_en=4'b0000 is still granted and changes no memory.
REQ-022 SHALL ignore addr[1:0]; word alignment is the memory's concern.
REQ-023 SHALL sustain back-to-back accesses: one grant per cycle, reads pipelined, rvalid for grant N coincident with grant N+1.
REQ-024 SHALL drive rdata of the non-owning port to 0.
REQ-025 SHALL, for a write then read of the same address in consecutive cycles, return the newly written data (memory write lands before the next read edge).

Reset
REQ-026 SHALL, while rst=1, force p0_gnt=p1_gnt=0, mem_write=0, mem_byte_en=0, both rvalid=0, wait counter=0, force1=0, pending-read flag=0.
REQ-027 SHALL drop an outstanding read when rst asserts between grant and response; no rvalid after rst deasserts.
REQ-028 SHALL accept requests on the first rising edge with rst=0.

Verification
REQ-029 SHALL cover: p0 write addr 0x00010 data 0xDEADBEEF byte_en 4'hF, then p0 read 0x00010 -> p0_rvalid next cycle, p0_rdata=0xDEADBEEF, p1_rvalid=0.
REQ-030 SHALL cover: p0 and p1 request together one cycle (wait=0) -> p0_gnt=1, p1_gnt=0, wait counter=1.
REQ-031 SHALL cover: p0_req and p1_req held high continuously, MAX_WAIT=4 -> p1 granted on 5th cycle, then p0 for 4 cycles, repeating.
REQ-032 SHALL cover: p1 write byte_en 4'b0010 data 0x0000AB00 to word holding 0x11223344, p1 read -> p1_rdata=0x1122AB44.
REQ-033 SHALL cover: p0 read granted, rst pulsed next cycle -> no p0_rvalid during or after reset; all outputs at reset values.
REQ-034 SHALL cover: four back-to-back p0 reads of 0x0,0x4,0x8,0xC -> four consecutive p0_rvalid cycles, data in address order.
